jk_mod_counter: RTL and testbench

- Parametrised synchronous modulo counter built from a row of JK flip-flop cells, one per bit.
- Generalises the single T-from-JK toggle stage to WIDTH bits.
- Adds programmable modulus wrap, up/down/hold/masked-toggle modes, parallel load, complementary outputs, terminal-count and error flags.
- Used as a clock-domain-local event counter and divider in the sequential-logic library.

---
 rtl/jk_seq_pkg.sv | 21 ++
 rtl/jk_mod_counter_if.sv | 24 ++
 rtl/jk_cell.sv | 39 +++
 rtl/jk_mod_counter.sv | 119 +++++++++++
 tb/tb_jk_mod_counter.sv | 114 +++++++++++
 5 files changed

// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared mode encodings and JK cell command type for the sequential library
package jk_seq_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // Encoding is the {j,k} pair applied to the cell.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET0 = 2'b01,
        JK_SET1   = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    function automatic jk_cmd_e jk_force(input logic d);
        return d ? JK_SET1 : JK_RESET0;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// rtl/jk_mod_counter_if.sv - control and status bundle of the JK modulo counter
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] tmask;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             err;

    modport master (
        output en, load, load_val, mode, tmask,
        input  q, qbar, tc, err
    );

    modport slave (
        input  en, load, load_val, mode, tmask,
        output q, qbar, tc, err
    );
endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with registered complementary output
module jk_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);
    logic q_d, q_q;
    logic q_bar_d, q_bar_q;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
        q_bar_d = ~q_d;
    end

    // q_bar has its own flop so it is never a gate delay behind q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q     <= RESET_BIT;
            q_bar_q <= ~RESET_BIT;
        end else begin
            q_q     <= q_d;
            q_bar_q <= q_bar_d;
        end
    end

    assign q     = q_q;
    assign q_bar = q_bar_q;
endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo up/down/masked-toggle counter built from a row of JK cells
module jk_mod_counter
    import jk_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input logic              clk,
    input logic              rst_n,
    jk_mod_counter_if.slave  bus
);
    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
            RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
            $error("jk_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] qbar_vec;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] tog;
    logic             use_force;
    logic             tc_c;
    logic             err_d, err_q;
    jk_cmd_e          cmd [WIDTH];

    // Plain increments/decrements and legal toggles drive only the changing bits with
    // TOGGLE; wraps, loads and illegal results force every bit to its target value.
    always_comb begin
        r         = q_vec ^ bus.tmask;
        nxt       = q_vec;
        tog       = '0;
        use_force = 1'b0;
        err_d     = 1'b0;
        tc_c      = 1'b0;
        if (bus.load) begin
            use_force = 1'b1;
            if ({1'b0, bus.load_val} < MOD_EXT) begin
                nxt = bus.load_val;
            end else begin
                nxt   = MAX_VAL;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    if (q_vec == MAX_VAL) begin
                        nxt       = '0;
                        use_force = 1'b1;
                        tc_c      = 1'b1;
                    end else begin
                        nxt = q_vec + WIDTH'(1);
                        tog = nxt ^ q_vec;
                    end
                end
                MODE_DOWN: begin
                    if (q_vec == '0) begin
                        nxt       = MAX_VAL;
                        use_force = 1'b1;
                        tc_c      = 1'b1;
                    end else begin
                        nxt = q_vec - WIDTH'(1);
                        tog = nxt ^ q_vec;
                    end
                end
                MODE_TOGGLE: begin
                    if ({1'b0, r} < MOD_EXT) begin
                        nxt = r;
                        tog = bus.tmask;
                    end else begin
                        nxt       = '0;
                        use_force = 1'b1;
                        err_d     = 1'b1;
                        tc_c      = 1'b1;
                    end
                end
                MODE_HOLD: nxt = q_vec;
                default:   nxt = q_vec;
            endcase
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (use_force)   cmd[i] = jk_force(nxt[i]);
            else if (tog[i]) cmd[i] = JK_TOGGLE;
            else             cmd[i] = JK_HOLD;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell #(
                .RESET_BIT (RST_VEC[gi])
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (cmd[gi][1]),
                .k     (cmd[gi][0]),
                .q     (q_vec[gi]),
                .q_bar (qbar_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.q    = q_vec;
    assign bus.qbar = qbar_vec;
    assign bus.tc   = tc_c & rst_n;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - scoreboard bench for jk_mod_counter (MODULUS 10 and 16 builds)
module tb_jk_mod_counter;
    import jk_seq_pkg::*;

    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    jk_mod_counter_if #(.WIDTH(4)) u_if ();
    jk_mod_counter_if #(.WIDTH(4)) u_if16 ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit sel, input logic rst, input logic en, input logic ld,
                        input logic [3:0] lv, input logic [1:0] md, input logic [3:0] tm,
                        input logic exp_tc, input logic [3:0] exp_q, input logic exp_err,
                        input string tag);
        exp_t e;
        logic [3:0] oq, oqb;
        logic       oerr, otc;
        rst_n = rst;
        u_if.en = 1'b0;   u_if.load = 1'b0;   u_if.load_val = '0;   u_if.mode = MODE_HOLD;   u_if.tmask = '0;
        u_if16.en = 1'b0; u_if16.load = 1'b0; u_if16.load_val = '0; u_if16.mode = MODE_HOLD; u_if16.tmask = '0;
        if (!sel) begin
            u_if.en = en; u_if.load = ld; u_if.load_val = lv; u_if.mode = md; u_if.tmask = tm;
        end else begin
            u_if16.en = en; u_if16.load = ld; u_if16.load_val = lv; u_if16.mode = md; u_if16.tmask = tm;
        end
        #1;
        otc = sel ? u_if16.tc : u_if.tc;
        check_eq({tag, "_tc"}, 32'(otc), 32'(exp_tc));
        sb.push_back('{sel, exp_q, exp_err});
        @(posedge clk);
        #1;
        e    = sb.pop_front();
        oq   = e.sel ? u_if16.q    : u_if.q;
        oqb  = e.sel ? u_if16.qbar : u_if.qbar;
        oerr = e.sel ? u_if16.err  : u_if.err;
        check_eq({tag, "_q"},    32'(oq),   32'(e.q));
        check_eq({tag, "_qbar"}, 32'(oqb),  32'(4'(~e.q)));
        check_eq({tag, "_err"},  32'(oerr), 32'(e.err));
    endtask

    initial begin
        rst_n = 1'b0;
        // reset overrides load; second edge also shows tc forced low in down mode at q==0
        step(0, 0, 1, 1, 4'd5, MODE_DOWN, 4'd0, 0, 4'd0, 0, "rst_load");
        step(0, 0, 1, 0, 4'd0, MODE_DOWN, 4'd0, 0, 4'd0, 0, "rst_tcmask");
        step(0, 1, 0, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd0, 0, "idle_en0_a");
        step(0, 1, 0, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd0, 0, "idle_en0_b");

        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 0, 4'd0, MODE_UP, 4'd0, ((i - 1) % 10) == 9, 4'(i % 10), 0,
                 $sformatf("up%0d", i));
        end

        step(0, 1, 0, 1, 4'd1, MODE_HOLD, 4'd0, 0, 4'd1, 0, "load1");
        step(0, 1, 1, 0, 4'd0, MODE_DOWN, 4'd0, 0, 4'd0, 0, "down_a");
        step(0, 1, 1, 0, 4'd0, MODE_DOWN, 4'd0, 1, 4'd9, 0, "down_wrap");
        step(0, 1, 1, 0, 4'd0, MODE_DOWN, 4'd0, 0, 4'd8, 0, "down_c");

        step(0, 1, 1, 1, 4'd12, MODE_UP,  4'd0, 0, 4'd9, 1, "bad_load");
        step(0, 1, 0, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd9, 0, "bad_load_clr");
        step(0, 1, 1, 0, 4'd0, MODE_HOLD, 4'd0, 0, 4'd9, 0, "mode_hold");

        step(0, 1, 0, 1, 4'd3, MODE_HOLD,   4'd0,    0, 4'd3, 0, "load3");
        step(0, 1, 1, 0, 4'd0, MODE_TOGGLE, 4'b0100, 0, 4'd7, 0, "tog_ok");
        step(0, 1, 1, 0, 4'd0, MODE_TOGGLE, 4'b1000, 1, 4'd0, 1, "tog_bad");
        step(0, 1, 1, 0, 4'd0, MODE_TOGGLE, 4'b0000, 0, 4'd0, 0, "tog_zero");

        step(0, 1, 0, 1, 4'd5, MODE_HOLD, 4'd0, 0, 4'd5, 0, "load5");
        step(0, 1, 1, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd6, 0, "up_to6");
        step(0, 0, 1, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd0, 0, "rst_mid");
        step(0, 1, 1, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd1, 0, "resume1");
        step(0, 1, 1, 0, 4'd0, MODE_UP,   4'd0, 0, 4'd2, 0, "resume2");

        step(1, 1, 0, 1, 4'd15, MODE_HOLD,  4'd0,    0, 4'd15, 0, "m16_load15");
        step(1, 1, 1, 0, 4'd0,  MODE_UP,    4'd0,    1, 4'd0,  0, "m16_wrap");
        step(1, 1, 1, 0, 4'd0,  MODE_TOGGLE, 4'b1111, 0, 4'd15, 0, "m16_tog");
        step(1, 1, 1, 0, 4'd0,  MODE_DOWN,  4'd0,    0, 4'd14, 0, "m16_down");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
